// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Multi-cycle multiply/divide unit beside the EX-stage ALU.
//                Runs MULT/MULTU by shift-add and DIV/DIVU by restoring
//                division, one bit per cycle. Owns HI/LO, serves MFHI/MFLO/
//                MTHI/MTLO and stalls the front of the pipeline while busy.
//                Optional macro MULDIV_FAST_MUL_EN replaces the iterative
//                multiply with a single-cycle multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int NB_DATA    = 32,
    parameter int NB_FUNCION = 6,
    parameter int NB_COUNT   = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [NB_FUNCION-1:0] i_inst_funcion,
    input  logic [NB_DATA-1:0]    i_rs,
    input  logic [NB_DATA-1:0]    i_rt,
    output logic                  o_stall,
    output logic [NB_DATA-1:0]    o_result,
    output logic [NB_DATA-1:0]    o_hi,
    output logic [NB_DATA-1:0]    o_lo,
    output logic                  o_done,
    output logic                  o_div_zero
);

    // ------------------------------------------------------------------------
    // Function codes and state encoding
    // ------------------------------------------------------------------------
    localparam logic [NB_FUNCION-1:0] C_FN_MFHI  = NB_FUNCION'(6'h10);
    localparam logic [NB_FUNCION-1:0] C_FN_MTHI  = NB_FUNCION'(6'h11);
    localparam logic [NB_FUNCION-1:0] C_FN_MFLO  = NB_FUNCION'(6'h12);
    localparam logic [NB_FUNCION-1:0] C_FN_MTLO  = NB_FUNCION'(6'h13);
    localparam logic [NB_FUNCION-1:0] C_FN_MULT  = NB_FUNCION'(6'h18);
    localparam logic [NB_FUNCION-1:0] C_FN_MULTU = NB_FUNCION'(6'h19);
    localparam logic [NB_FUNCION-1:0] C_FN_DIV   = NB_FUNCION'(6'h1A);
    localparam logic [NB_FUNCION-1:0] C_FN_DIVU  = NB_FUNCION'(6'h1B);

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_MUL  = 3'd1;
    localparam logic [2:0] C_ST_DIV  = 3'd2;
    localparam logic [2:0] C_ST_FIX  = 3'd3;
    localparam logic [2:0] C_ST_DONE = 3'd4;

    localparam logic [NB_COUNT-1:0] C_LAST_ITER = NB_COUNT'(NB_DATA - 1);
    localparam logic [NB_COUNT-1:0] C_COUNT_ONE = NB_COUNT'(1);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [NB_COUNT-1:0]  r_count;
    // Multiply: {partial product, remaining multiplier}. Divide: low half
    // holds the dividend being shifted out and the quotient shifted in.
    logic [2*NB_DATA-1:0] r_acc;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [NB_DATA-1:0]   r_opnd;
    // One extra bit so the shifted partial remainder never overflows.
    logic [NB_DATA:0]     r_rem;
    logic                 r_is_div;
    logic                 r_neg_main;   // product sign or quotient sign
    logic                 r_neg_rem;    // remainder follows the dividend
    logic [NB_DATA-1:0]   r_hi;
    logic [NB_DATA-1:0]   r_lo;
    logic                 r_div_zero;

    // ------------------------------------------------------------------------
    // Instruction decode and operand conditioning
    // ------------------------------------------------------------------------
    logic               w_is_mult;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_is_mfhi;
    logic               w_is_mflo;
    logic               w_is_mthi;
    logic               w_is_mtlo;
    logic               w_is_read;
    logic               w_is_muldiv;
    logic               w_rt_zero;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [NB_DATA-1:0] w_mag_rs;
    logic [NB_DATA-1:0] w_mag_rt;

    assign w_is_mult   = (i_inst_funcion == C_FN_MULT) || (i_inst_funcion == C_FN_MULTU);
    assign w_is_div    = (i_inst_funcion == C_FN_DIV)  || (i_inst_funcion == C_FN_DIVU);
    assign w_is_signed = (i_inst_funcion == C_FN_MULT) || (i_inst_funcion == C_FN_DIV);
    assign w_is_mfhi   = (i_inst_funcion == C_FN_MFHI);
    assign w_is_mflo   = (i_inst_funcion == C_FN_MFLO);
    assign w_is_mthi   = (i_inst_funcion == C_FN_MTHI);
    assign w_is_mtlo   = (i_inst_funcion == C_FN_MTLO);
    assign w_is_read   = w_is_mfhi || w_is_mflo;
    assign w_is_muldiv = w_is_mult || w_is_div || w_is_read || w_is_mthi || w_is_mtlo;
    assign w_rt_zero   = (i_rt == '0);

    // Unsigned ops keep raw operands; signed ops work on magnitudes. The
    // magnitude of the most negative value is itself read as unsigned.
    assign w_rs_neg = w_is_signed & i_rs[NB_DATA-1];
    assign w_rt_neg = w_is_signed & i_rt[NB_DATA-1];
    assign w_mag_rs = w_rs_neg ? -i_rs : i_rs;
    assign w_mag_rt = w_rt_neg ? -i_rt : i_rt;

    // ------------------------------------------------------------------------
    // Per-iteration arithmetic
    // ------------------------------------------------------------------------
    logic [NB_DATA:0]   w_mul_sum;
    logic [NB_DATA:0]   w_div_shift;
    logic [NB_DATA:0]   w_div_diff;
    logic               w_div_ge;
    logic [NB_DATA-1:0] w_quot_fix;
    logic [NB_DATA-1:0] w_rem_fix;
    logic [2*NB_DATA-1:0] w_prod_fix;

    // Shift-add: add the multiplicand to the upper half when the current
    // multiplier bit is set; the carry lands in the top bit of the sum.
    assign w_mul_sum = {1'b0, r_acc[2*NB_DATA-1:NB_DATA]}
                     + (r_acc[0] ? {1'b0, r_opnd} : {(NB_DATA+1){1'b0}});

    // Restoring step: bring the next dividend bit into the partial remainder
    // and subtract the divisor only if it fits.
    assign w_div_shift = {r_rem[NB_DATA-1:0], r_acc[NB_DATA-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_diff  = w_div_shift - {1'b0, r_opnd};

    // Sign correction applied in FIX.
    assign w_quot_fix = r_neg_main ? -r_acc[NB_DATA-1:0] : r_acc[NB_DATA-1:0];
    assign w_rem_fix  = r_neg_rem  ? -r_rem[NB_DATA-1:0] : r_rem[NB_DATA-1:0];
    assign w_prod_fix = r_neg_main ? -r_acc : r_acc;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (i_valid && w_is_mult) begin
`ifdef MULDIV_FAST_MUL_EN
                    w_state_next = C_ST_FIX;
`else
                    w_state_next = C_ST_MUL;
`endif
                end else if (i_valid && w_is_div) begin
                    w_state_next = w_rt_zero ? C_ST_DONE : C_ST_DIV;
                end
            end
            C_ST_MUL:  w_state_next = (r_count == C_LAST_ITER) ? C_ST_FIX : C_ST_MUL;
            C_ST_DIV:  w_state_next = (r_count == C_LAST_ITER) ? C_ST_FIX : C_ST_DIV;
            C_ST_FIX:  w_state_next = C_ST_DONE;
            C_ST_DONE: w_state_next = C_ST_IDLE;
            default:   w_state_next = C_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs: done pulse, stall, and MFHI/MFLO read mux
    // ------------------------------------------------------------------------
    always_comb begin
        o_done   = (r_state == C_ST_DONE);
        o_stall  = 1'b0;
        o_result = '0;
        // Reads are released in DONE since HI/LO were written at its entry.
        // New operations still wait that cycle: they are only accepted in IDLE.
        if (i_valid && w_is_muldiv && (r_state != C_ST_IDLE)) begin
            o_stall = !((r_state == C_ST_DONE) && w_is_read);
        end
        if (i_valid && w_is_mfhi) begin
            o_result = r_hi;
        end else if (i_valid && w_is_mflo) begin
            o_result = r_lo;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath: operand capture, iteration, sign fix-up, HI/LO and flag
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count    <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_rem      <= '0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (i_valid && w_is_mult) begin
                        r_div_zero <= 1'b0;
                        r_is_div   <= 1'b0;
                        r_neg_main <= w_rs_neg ^ w_rt_neg;
                        r_count    <= '0;
`ifdef MULDIV_FAST_MUL_EN
                        r_acc      <= {{NB_DATA{1'b0}}, w_mag_rs} * {{NB_DATA{1'b0}}, w_mag_rt};
`else
                        r_opnd     <= w_mag_rs;
                        r_acc      <= {{NB_DATA{1'b0}}, w_mag_rt};
`endif
                    end else if (i_valid && w_is_div) begin
                        r_div_zero <= w_rt_zero;
                        if (w_rt_zero) begin
                            // No iteration: quotient saturates, dividend kept.
                            r_hi <= i_rs;
                            r_lo <= '1;
                        end else begin
                            r_is_div   <= 1'b1;
                            r_neg_main <= w_rs_neg ^ w_rt_neg;
                            r_neg_rem  <= w_rs_neg;
                            r_opnd     <= w_mag_rt;
                            r_acc      <= {{NB_DATA{1'b0}}, w_mag_rs};
                            r_rem      <= '0;
                            r_count    <= '0;
                        end
                    end else if (i_valid && w_is_mthi) begin
                        r_hi <= i_rs;
                    end else if (i_valid && w_is_mtlo) begin
                        r_lo <= i_rs;
                    end
                end
                C_ST_MUL: begin
                    r_acc   <= {w_mul_sum, r_acc[NB_DATA-1:1]};
                    r_count <= r_count + C_COUNT_ONE;
                end
                C_ST_DIV: begin
                    r_rem              <= w_div_ge ? w_div_diff : w_div_shift;
                    r_acc[NB_DATA-1:0] <= {r_acc[NB_DATA-2:0], w_div_ge};
                    r_count            <= r_count + C_COUNT_ONE;
                end
                C_ST_FIX: begin
                    if (r_is_div) begin
                        r_lo <= w_quot_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*NB_DATA-1:NB_DATA];
                        r_lo <= w_prod_fix[NB_DATA-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_hi       = r_hi;
    assign o_lo       = r_lo;
    assign o_div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Directed scoreboard bench for muldiv_sequencer. Expected
//                HI/LO/flag/latency and MFHI/MFLO values are queued at issue
//                time and compared by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int c_nb = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int c_mul_lat = 2;
`else
    localparam int c_mul_lat = c_nb + 2;
`endif
    localparam int c_div_lat = c_nb + 2;

    localparam logic [5:0] c_fn_mfhi  = 6'h10;
    localparam logic [5:0] c_fn_mthi  = 6'h11;
    localparam logic [5:0] c_fn_mflo  = 6'h12;
    localparam logic [5:0] c_fn_mtlo  = 6'h13;
    localparam logic [5:0] c_fn_mult  = 6'h18;
    localparam logic [5:0] c_fn_multu = 6'h19;
    localparam logic [5:0] c_fn_div   = 6'h1A;
    localparam logic [5:0] c_fn_divu  = 6'h1B;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          acc;
        int          lat;
    } exp_t;

    logic        r_clk   = 1'b0;
    logic        r_rst_n = 1'b1;
    logic        r_valid = 1'b0;
    logic [5:0]  r_func  = '0;
    logic [31:0] r_rs    = '0;
    logic [31:0] r_rt    = '0;

    logic        w_stall;
    logic [31:0] w_result;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    logic        w_done;
    logic        w_div_zero;

    int          n_chk    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    int          exp_done = 0;

    exp_t        sb_q[$];
    logic [31:0] rd_q[$];

    muldiv_sequencer dut (
        .i_clock        (r_clk),
        .i_reset        (r_rst_n),
        .i_valid        (r_valid),
        .i_inst_funcion (r_func),
        .i_rs           (r_rs),
        .i_rt           (r_rt),
        .o_stall        (w_stall),
        .o_result       (w_result),
        .o_hi           (w_hi),
        .o_lo           (w_lo),
        .o_done         (w_done),
        .o_div_zero     (w_div_zero)
    );

    always #5 r_clk = ~r_clk;

    always @(posedge r_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: completion pulses against the scoreboard, reads against rd_q.
    always @(negedge r_clk) begin
        exp_t e;
        if (r_rst_n && w_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got o_done=1 expected no pending operation (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("done_hi", w_hi, e.hi);
                check("done_lo", w_lo, e.lo);
                check("done_div_zero", {31'd0, w_div_zero}, {31'd0, e.dz});
                check("done_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
        if (r_rst_n && r_valid && (r_func == c_fn_mfhi || r_func == c_fn_mflo) && !w_stall) begin
            if (rd_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_read: got o_result=0x%08h expected no read (cycle %0d)", w_result, cyc);
            end else begin
                check("read_result", w_result, rd_q.pop_front());
            end
        end
    end

    // Drive one operation; caller is positioned just after a rising edge.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] hi, input logic [31:0] lo,
                         input logic dz, input int lat);
        exp_t e;
        r_valid = 1'b1;
        r_func  = f;
        r_rs    = a;
        r_rt    = b;
        @(posedge r_clk);
        #1;
        r_valid = 1'b0;
        if (push) begin
            e.hi  = hi;
            e.lo  = lo;
            e.dz  = dz;
            e.acc = cyc;
            e.lat = lat;
            sb_q.push_back(e);
            exp_done++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge r_clk);
            n++;
        end
        #1;
        n_chk++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL done_timeout: got %0d pending entries expected 0 after %0d cycles", sb_q.size(), n);
            sb_q.delete();
        end
        @(posedge r_clk);
        #1;
    endtask

    initial begin
        int n;
        #1 r_rst_n = 1'b0;
        repeat (3) @(posedge r_clk);
        @(negedge r_clk);
        check("reset_hi", w_hi, 32'h0);
        check("reset_lo", w_lo, 32'h0);
        check("reset_done", {31'd0, w_done}, 32'h0);
        check("reset_div_zero", {31'd0, w_div_zero}, 32'h0);
        check("reset_stall", {31'd0, w_stall}, 32'h0);
        check("reset_result", w_result, 32'h0);
        @(posedge r_clk);
        #1 r_rst_n = 1'b1;
        @(posedge r_clk);
        #1;

        // multu 0xFFFFFFFF * 2, stall observed while the request is held
        issue(c_fn_multu, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, c_mul_lat);
        r_valid = 1'b1;
        r_func  = c_fn_multu;
        @(negedge r_clk);
        check("multu_stall_held", {31'd0, w_stall}, 32'h1);
        @(posedge r_clk);
        #1 r_valid = 1'b0;
        wait_idle();

        issue(c_fn_mult, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, c_mul_lat);
        wait_idle();
        issue(c_fn_mult, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0, 1'b0, c_mul_lat);
        wait_idle();
        issue(c_fn_div, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, c_div_lat);
        wait_idle();
        issue(c_fn_divu, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, c_div_lat);
        wait_idle();
        issue(c_fn_divu, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'hF, 32'h0FFF_FFFF, 1'b0, c_div_lat);
        wait_idle();
        issue(c_fn_div, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0, c_div_lat);
        wait_idle();

        // Divide by zero, sticky flag, cleared by the next accepted mult
        issue(c_fn_divu, 32'h1234, 32'h0, 1'b1, 32'h1234, 32'hFFFF_FFFF, 1'b1, 1);
        wait_idle();
        @(negedge r_clk);
        check("div_zero_sticky", {31'd0, w_div_zero}, 32'h1);
        @(posedge r_clk);
        #1;
        issue(c_fn_mult, 32'd7, 32'd6, 1'b1, 32'h0, 32'd42, 1'b0, c_mul_lat);
        check("div_zero_cleared", {31'd0, w_div_zero}, 32'h0);
        wait_idle();

        // Divide followed by an mflo held in EX until the result is ready
        issue(c_fn_div, 32'd1000, 32'd3, 1'b1, 32'd1, 32'd333, 1'b0, c_div_lat);
        r_valid = 1'b1;
        r_func  = c_fn_mflo;
        rd_q.push_back(32'd333);
        n = 0;
        @(negedge r_clk);
        while (w_stall && n < 100) begin
            n++;
            @(negedge r_clk);
        end
        check("mflo_stall_cycles", 32'(n), 32'(c_div_lat - 1));
        check("mflo_released_in_done", {31'd0, w_done}, 32'h1);
        @(posedge r_clk);
        #1 r_valid = 1'b0;
        wait_idle();

        // mtlo / mthi / mfhi in IDLE
        r_valid = 1'b1;
        r_func  = c_fn_mtlo;
        r_rs    = 32'h0000_ABCD;
        @(negedge r_clk);
        check("mtlo_stall", {31'd0, w_stall}, 32'h0);
        @(posedge r_clk);
        #1;
        r_func = c_fn_mthi;
        r_rs   = 32'h0000_5555;
        @(negedge r_clk);
        check("mtlo_lo", w_lo, 32'h0000_ABCD);
        @(posedge r_clk);
        #1;
        r_func = c_fn_mfhi;
        rd_q.push_back(32'h0000_5555);
        @(negedge r_clk);
        check("mthi_hi", w_hi, 32'h0000_5555);
        @(posedge r_clk);
        #1;

        // Non-muldiv function is ignored
        r_func = 6'h20;
        r_rs   = 32'h9999_9999;
        @(negedge r_clk);
        check("other_fn_stall", {31'd0, w_stall}, 32'h0);
        @(posedge r_clk);
        #1 r_valid = 1'b0;
        @(negedge r_clk);
        check("other_fn_hi", w_hi, 32'h0000_5555);
        check("other_fn_lo", w_lo, 32'h0000_ABCD);
        @(posedge r_clk);
        #1;

        // Reset in the tenth cycle of a divide aborts it
        issue(c_fn_divu, 32'd500, 32'd3, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        repeat (9) @(posedge r_clk);
        #1 r_rst_n = 1'b0;
        @(negedge r_clk);
        check("abort_hi", w_hi, 32'h0);
        check("abort_lo", w_lo, 32'h0);
        check("abort_done", {31'd0, w_done}, 32'h0);
        @(posedge r_clk);
        #1 r_rst_n = 1'b1;
        repeat (40) @(posedge r_clk);
        #1;
        r_valid = 1'b1;
        r_func  = c_fn_mflo;
        rd_q.push_back(32'h0);
        @(posedge r_clk);
        #1 r_valid = 1'b0;
        @(posedge r_clk);
        #1;

        check("done_pulse_count", 32'(done_cnt), 32'(exp_done));
        check("reads_consumed", 32'(rd_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation time limit expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide unit with its own sequencer, placed beside the EX-stage ALU.
- Executes R-type MULT/MULTU/DIV/DIVU iteratively and owns the HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO.
- Drives a stall to the hazard logic while an operation is in flight.

Parameters:
- NB_DATA, 32, operand/HI/LO width.
- NB_FUNCION, 6, width of the R-type function field.
- NB_COUNT, 6, iteration counter width; must hold NB_DATA.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  reset: one clock; reset is asynchronous and active-low.
- i_valid  in  1  EX stage holds a muldiv-class instruction this cycle.
- i_inst_funcion  in  NB_FUNCION  function field:
  - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu
  - 0x10 mfhi, 0x12 mflo, 0x11 mthi, 0x13 mtlo
- i_rs  in  NB_DATA  rs operand (multiplicand/dividend; source for mthi/mtlo).
- i_rt  in  NB_DATA  rt operand (multiplier/divisor).
- o_stall  out  1  freeze IF/ID/EX.
- o_result  out  NB_DATA  HI or LO for mfhi/mflo.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.
- o_done  out  1  one-cycle pulse when HI/LO are updated by mult/div.
- o_div_zero  out  1  last divide had divisor 0; sticky until next accepted mult/div.

Behaviour:
- Reset (async, any state): state=IDLE, HI=LO=0, counter=0, o_done=0, o_div_zero=0, o_stall=0, o_result=0.
- Any non-listed function with i_valid=1 is ignored: no state change, no stall.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - i_valid & mult/multu:
    - latch |rs|, |rt| (absolute values only for signed mult; raw for multu); record result sign = rs[MSB]^rt[MSB] for signed.
    - counter=0 -> MUL.
  - i_valid & div/divu, rt!=0:
    - latch magnitudes as for mult; record quotient sign = rs^rt MSB and remainder sign = rs MSB (signed only).
    - -> DIV.
  - i_valid & div/divu, rt==0:
    - LO=all ones, HI=rs, o_div_zero=1 -> DONE.
  - mthi/mtlo: HI/LO=rs at the clock edge; stay IDLE, no stall.
  - mfhi/mflo: o_result = HI/LO combinationally; no stall.
- MUL:
  - Shift-add, one multiplier bit per cycle into a 2*NB_DATA accumulator.
  - NB_DATA cycles, then -> FIX.
- DIV:
  - Restoring division, one quotient bit per cycle.
  - Remainder register is NB_DATA+1 bits, so the subtract never overflows.
  - NB_DATA cycles, then -> FIX.
- FIX:
  - Apply two's-complement negation per recorded signs.
  - Write HI:LO (mult: HI=upper, LO=lower; div: LO=quotient, HI=remainder).
  - -> DONE.
- DONE: o_done=1 for this cycle only -> IDLE.
- Latency, accept edge to o_done cycle:
  - NB_DATA+2 cycles (34 at default).
  - Divide-by-zero: 1 cycle.
- o_stall:
  - 1 whenever state!=IDLE and i_valid=1 with any muldiv function.
  - Deasserts in the DONE cycle, so a waiting mfhi/mflo reads the fresh HI/LO that cycle.
  - Non-muldiv instructions are not stalled.
- Requests arriving while not IDLE are not accepted; the pipeline holds them via the stall.
- HI/LO keep their old values until the FIX write; mthi/mtlo never overlap an operation.
- Overflow case: signed -2^31 / -1 gives LO=0x80000000, HI=0; no flag.
- Reset asserted mid-operation aborts it; HI/LO return to 0.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - mult/multu skip MUL and compute the full product with a single-cycle multiplier in IDLE.
  - Product registered, then FIX and DONE; latency 2 cycles.
  - Division is unchanged.
- Undefined: iterative MUL path as specified; no hardware multiplier is inferred.

Test Plan:
- multu rs=0xFFFFFFFF, rt=2 -> o_done 34 cycles after accept; HI=0x00000001, LO=0xFFFFFFFE; o_stall high while i_valid held.
- mult rs=-3, rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- div rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu rs=100, rt=7 -> LO=14, HI=2.
- divu rs=0x1234, rt=0 -> o_done 1 cycle after accept; LO=0xFFFFFFFF, HI=0x1234, o_div_zero=1; a following mult clears the flag.
- Pipeline sequence:
  - Issue div, then hold mflo with i_valid=1 -> o_stall=1 until the DONE cycle, where o_result=quotient.
  - mtlo 0xABCD in IDLE -> LO=0xABCD next cycle with no stall.
  - Assert i_reset=0 at cycle 10 of a div -> IDLE, HI=LO=0, o_done never pulses.
